// File: rtl/divider_toplevel.sv
// Sequential restoring divider: one quotient bit per clock, Load/Run/SW operator flow.
// Define DIVIDER_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module divider_toplevel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done,
  output logic             Div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_low_q, run_low_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef DIVIDER_SIGNED_EN
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction
`endif

  logic             start_c;
  logic [WIDTH:0]   a_sh_c;
  logic [WIDTH:0]   trial_c;

  // run_low_q resets to 0, so a Run held high through reset release is not an edge
  assign start_c = Run & run_low_q;
  assign a_sh_c  = {a_q, q_q[WIDTH-1]};
  assign trial_c = a_sh_c - {1'b0, d_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    run_low_d = ~Run;
    busy_d    = busy_q;
    done_d    = done_q;
    dbz_d     = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    negq_d    = negq_q;
    negr_d    = negr_q;
`endif
    if (Load) begin
      state_d = S_IDLE;
      q_d     = SW;
      a_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_c) begin
            d_d     = SW;
            a_d     = '0;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_CALC;
`ifdef DIVIDER_SIGNED_EN
            // Zero divisor keeps the raw dividend so it can be reported as remainder
            if (SW != '0) begin
              d_d    = abs_f(SW);
              q_d    = abs_f(q_q);
              negq_d = q_q[WIDTH-1] ^ SW[WIDTH-1];
              negr_d = q_q[WIDTH-1];
            end
`endif
          end
        end
        S_CALC: begin
          if (d_q == '0) begin
            a_d     = q_q;
            q_d     = '1;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            a_d   = trial_c[WIDTH] ? a_sh_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], ~trial_c[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef DIVIDER_SIGNED_EN
              state_d = S_FIXUP;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
`endif
            end
          end
        end
        S_FIXUP: begin
`ifdef DIVIDER_SIGNED_EN
          if (negq_q) q_d = ~q_q + WIDTH'(1);
          if (negr_q) a_d = ~a_q + WIDTH'(1);
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      run_low_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      run_low_q <= run_low_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      negq_q    <= negq_d;
      negr_q    <= negr_d;
`endif
    end
  end

  assign Aval        = a_q;
  assign Bval        = q_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_toplevel.sv
// Randomized self-checking bench for divider_toplevel against an arithmetic reference model.
module tb_divider_toplevel;

  localparam int unsigned W = 8;
`ifdef DIVIDER_SIGNED_EN
  localparam int unsigned SGN = 1;
`else
  localparam int unsigned SGN = 0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Load = 1'b0;
  logic         Run = 1'b0;
  logic [W-1:0] SW = '0;
  logic [W-1:0] Aval, Bval;
  logic         Busy, Done, Div_by_zero;

  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] cur = '0;

  divider_toplevel #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .Run(Run), .SW(SW),
    .Aval(Aval), .Bval(Bval), .Busy(Busy), .Done(Done), .Div_by_zero(Div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  // Reference: plain integer division, truncating toward zero in the signed build
  task automatic ref_div(input logic [W-1:0] n, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int ns, ds;
    if (dv == '0) begin
      q = '1; r = n; z = 1'b1;
    end else if (SGN != 0) begin
      ns = $signed(n);
      ds = $signed(dv);
      q = W'(ns / ds);
      r = W'(ns % ds);
      z = 1'b0;
    end else begin
      q = n / dv; r = n % dv; z = 1'b0;
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    Load = 1'b1;
    SW   = v;
    cycle();
    Load = 1'b0;
    cur  = v;
  endtask

  task automatic run_div(input logic [W-1:0] dv, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    ref_div(cur, dv, eq, er, ez);
    Run = 1'b0;
    cycle();
    Run = 1'b1;
    SW  = dv;
    cycle();
    Run = 1'b0;
    SW  = W'($urandom);
    check({tag, "_done_clr"}, 32'(Done), 32'd0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (k == 1 && dv != '0 && !Done) check({tag, "_busy"}, 32'(Busy), 32'd1);
      if (Done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), (dv == '0) ? 32'd1 : 32'(W + SGN));
    check({tag, "_quot"}, 32'(Bval), 32'(eq));
    check({tag, "_rem"}, 32'(Aval), 32'(er));
    check({tag, "_dbz"}, 32'(Div_by_zero), 32'(ez));
    check({tag, "_idle"}, 32'(Busy), 32'd0);
    cur = eq;
  endtask

  initial begin
    #1;
    check("rst_aval", 32'(Aval), 32'd0);
    check("rst_bval", 32'(Bval), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_dbz", 32'(Div_by_zero), 32'd0);
    // Run held high through reset release must not start
    Run = 1'b1;
    #13;
    Reset_n = 1'b1;
    repeat (3) cycle();
    check("rst_run_held", 32'(Busy), 32'd0);
    Run = 1'b0;
    cycle();

    do_load(8'd100);
    run_div(8'd7, "d100_7");
    if (SGN == 0) begin
      check("d100_7_q_const", 32'(Bval), 32'd14);
      check("d100_7_r_const", 32'(Aval), 32'd2);
    end
    do_load(8'd255);
    run_div(8'd1, "d255_1");
    run_div(8'd255, "chain_255");
    do_load(8'd37);
    run_div(8'd0, "d37_0");
    check("d37_0_q_const", 32'(Bval), 32'hFF);
    check("d37_0_r_const", 32'(Aval), 32'd37);

    // Abort mid-calc with Load; Run then stays high and must not restart
    do_load(8'd200);
    Run = 1'b0;
    cycle();
    Run = 1'b1;
    SW  = 8'd3;
    repeat (4) cycle();
    Load = 1'b1;
    SW   = 8'd9;
    cycle();
    Load = 1'b0;
    cur  = 8'd9;
    check("abort_bval", 32'(Bval), 32'd9);
    check("abort_aval", 32'(Aval), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    repeat (5) cycle();
    check("held_run_busy", 32'(Busy), 32'd0);
    check("held_run_done", 32'(Done), 32'd0);
    Run = 1'b0;

    // Asynchronous reset in the middle of a division
    do_load(8'd50);
    Run = 1'b0;
    cycle();
    Run = 1'b1;
    SW  = 8'd5;
    repeat (3) cycle();
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_aval", 32'(Aval), 32'd0);
    check("arst_bval", 32'(Bval), 32'd0);
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_done", 32'(Done), 32'd0);
    #3;
    Reset_n = 1'b1;
    repeat (2) cycle();
    check("arst_run_held", 32'(Busy), 32'd0);
    Run = 1'b0;
    cur = '0;

    if (SGN != 0) begin
      do_load(8'h9C);
      run_div(8'd7, "s_m100_7");
      check("s_m100_7_q_const", 32'(Bval), 32'hF2);
      check("s_m100_7_r_const", 32'(Aval), 32'hFE);
      do_load(8'h80);
      run_div(8'hFF, "s_min_m1");
      check("s_min_m1_q_const", 32'(Bval), 32'h80);
      check("s_min_m1_r_const", 32'(Aval), 32'h00);
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] dv;
      if ($urandom_range(3) != 0) do_load(W'($urandom));
      case ($urandom_range(7))
        0:       dv = '0;
        1:       dv = W'($urandom_range(3) + 1);
        default: dv = W'($urandom);
      endcase
      run_div(dv, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
